// File: rtl/mult_seq_arbiter_if.sv
// mult_seq_arbiter_if: requester-side handshake and tagged result bus of the shared scaling unit.
interface mult_seq_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] d_flat;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic               out_valid;
    logic [DW+2:0]      out;
    logic [IDW-1:0]     out_id;
    logic [1:0]         out_phase;
    modport master (output req, d_flat, input gnt, busy, out_valid, out, out_id, out_phase);
    modport slave (input req, d_flat, output gnt, busy, out_valid, out, out_id, out_phase);
endinterface

// File: rtl/mult_seq_arbiter.sv
// mult_seq_arbiter: round-robin arbiter feeding a 4-phase constant-scaling sequencer.
module mult_seq_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int DW   = 8,
    parameter int C0   = 8,
    parameter int C1   = 1,
    parameter int C2   = 3,
    parameter int C3   = 7
) (
    input logic               clk,
    input logic               rst,
    mult_seq_arbiter_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nx;
    logic [1:0]      phase, phase_nx;
    logic [DW-1:0]   opnd, opnd_nx;
    logic [IDW-1:0]  id, id_nx, ptr, ptr_nx, win;
    logic [NREQ-1:0] gnt, gnt_nx;
    logic            found, arb, run;
    logic [DW+2:0]   prod;

    // Coefficients are at most 8, so four shifted partial sums cover every value.
    function automatic logic [DW+2:0] scale(input logic [DW-1:0] v, input int c);
        scale = '0;
        for (int b = 0; b < 4; b++)
            if (c[b]) scale = scale + ((DW+3)'(v) << b);
    endfunction

    // Descending scan so the candidate closest to ptr is assigned last and wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (bus.req[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + k) % NREQ);
            end
    end

    always_comb begin
        arb      = (state == IDLE) || (phase == 2'd3);
        state_nx = arb ? (found ? RUN : IDLE) : state;
        phase_nx = arb ? 2'd0 : phase + 2'd1;
        opnd_nx  = (arb && found) ? bus.d_flat[int'(win)*DW +: DW] : opnd;
        id_nx    = (arb && found) ? win : id;
        ptr_nx   = (arb && found) ? IDW'((int'(win) + 1) % NREQ) : ptr;
        gnt_nx   = (arb && found) ? NREQ'(1) << win : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            phase <= '0;
            opnd  <= '0;
            id    <= '0;
            ptr   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            opnd  <= opnd_nx;
            id    <= id_nx;
            ptr   <= ptr_nx;
            gnt   <= gnt_nx;
        end
    end

    assign run  = state == RUN;
    assign prod = phase == 2'd0 ? scale(opnd, C0) :
                  phase == 2'd1 ? scale(opnd, C1) :
                  phase == 2'd2 ? scale(opnd, C2) : scale(opnd, C3);

    assign bus.gnt       = gnt;
    assign bus.busy      = run;
    assign bus.out_valid = run;
    assign bus.out_phase = run ? phase : 2'd0;
    assign bus.out_id    = run ? id : '0;
    assign bus.out       = run ? prod : '0;
endmodule

// File: tb/tb_mult_seq_arbiter.sv
// tb_mult_seq_arbiter: directed vector table plus reset-abort and idle sequences.
module tb_mult_seq_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_seq_arbiter_if #(.NREQ(4), .IDW(2), .DW(8)) bus ();
    mult_seq_arbiter #(.NREQ(4), .IDW(2), .DW(8), .C0(8), .C1(1), .C2(3), .C3(7)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] d;
        logic [3:0]  gnt;
        logic        busy;
        int          out;
        int          id;
        int          ph;
    } vec_t;

    vec_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic r, input logic [3:0] rq, input logic [31:0] d,
                               input logic [3:0] g, input logic b, input int o, input int id, input int ph);
        vec_t x;
        x.rst = r; x.req = rq; x.d = d; x.gnt = g; x.busy = b; x.out = o; x.id = id; x.ph = ph;
        return x;
    endfunction

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.d_flat = '0;
        // single request from requester 0
        q.push_back(v(1, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0));
        q.push_back(v(0, 4'h1, 32'h10, 4'h1, 1, 128, 0, 0));
        q.push_back(v(0, 4'h0, 32'h10, 4'h0, 1, 16, 0, 1));
        q.push_back(v(0, 4'h0, 32'h10, 4'h0, 1, 48, 0, 2));
        q.push_back(v(0, 4'h0, 32'h10, 4'h0, 1, 112, 0, 3));
        q.push_back(v(0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0));
        // all four held: round robin, no bubbles
        q.push_back(v(1, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h1, 1, 8, 0, 0));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h0, 1, 1, 0, 1));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h0, 1, 3, 0, 2));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h0, 1, 7, 0, 3));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h2, 1, 16, 1, 0));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h0, 1, 2, 1, 1));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h0, 1, 6, 1, 2));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h0, 1, 14, 1, 3));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h4, 1, 24, 2, 0));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h0, 1, 3, 2, 1));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h0, 1, 9, 2, 2));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h0, 1, 21, 2, 3));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h8, 1, 32, 3, 0));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h0, 1, 4, 3, 1));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h0, 1, 12, 3, 2));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h0, 1, 28, 3, 3));
        q.push_back(v(0, 4'hF, 32'h04030201, 4'h1, 1, 8, 0, 0));
        q.push_back(v(1, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0));
        // max operand, then ptr=3 favours requester 3 over 1
        q.push_back(v(0, 4'h4, 32'h00FF0000, 4'h4, 1, 2040, 2, 0));
        q.push_back(v(0, 4'h0, 32'h00FF0000, 4'h0, 1, 255, 2, 1));
        q.push_back(v(0, 4'h0, 32'h00FF0000, 4'h0, 1, 765, 2, 2));
        q.push_back(v(0, 4'h0, 32'h00FF0000, 4'h0, 1, 1785, 2, 3));
        q.push_back(v(0, 4'hA, 32'h09000500, 4'h8, 1, 72, 3, 0));
        q.push_back(v(0, 4'h2, 32'h09000500, 4'h0, 1, 9, 3, 1));
        q.push_back(v(0, 4'h2, 32'h09000500, 4'h0, 1, 27, 3, 2));
        q.push_back(v(0, 4'h2, 32'h09000500, 4'h0, 1, 63, 3, 3));
        q.push_back(v(0, 4'h2, 32'h09000500, 4'h2, 1, 40, 1, 0));
        q.push_back(v(0, 4'h0, 32'h09000500, 4'h0, 1, 5, 1, 1));
        q.push_back(v(0, 4'h0, 32'h09000500, 4'h0, 1, 15, 1, 2));
        q.push_back(v(0, 4'h0, 32'h09000500, 4'h0, 1, 35, 1, 3));
        q.push_back(v(0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0));
        // operand change and new request mid-sequence
        q.push_back(v(0, 4'h1, 32'h00000002, 4'h1, 1, 16, 0, 0));
        q.push_back(v(0, 4'h2, 32'h00000433, 4'h0, 1, 2, 0, 1));
        q.push_back(v(0, 4'h2, 32'h00000433, 4'h0, 1, 6, 0, 2));
        q.push_back(v(0, 4'h2, 32'h00000433, 4'h0, 1, 14, 0, 3));
        q.push_back(v(0, 4'h2, 32'h00000433, 4'h2, 1, 32, 1, 0));
        q.push_back(v(0, 4'h0, 32'h00000433, 4'h0, 1, 4, 1, 1));
        q.push_back(v(0, 4'h0, 32'h00000433, 4'h0, 1, 12, 1, 2));
        q.push_back(v(0, 4'h0, 32'h00000433, 4'h0, 1, 28, 1, 3));
        q.push_back(v(0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0));
        // reset during phase 2 aborts and returns ptr to 0
        q.push_back(v(0, 4'h1, 32'h00000003, 4'h1, 1, 24, 0, 0));
        q.push_back(v(0, 4'h0, 32'h00000003, 4'h0, 1, 3, 0, 1));
        q.push_back(v(0, 4'h0, 32'h00000003, 4'h0, 1, 9, 0, 2));
        q.push_back(v(1, 4'h0, 32'h00000003, 4'h0, 0, 0, 0, 0));
        q.push_back(v(0, 4'hA, 32'h09000500, 4'h2, 1, 40, 1, 0));
        q.push_back(v(0, 4'h8, 32'h09000500, 4'h0, 1, 5, 1, 1));
        q.push_back(v(1, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0));

        for (int i = 0; i < q.size(); i++) begin
            rst = q[i].rst;
            bus.req = q[i].req;
            bus.d_flat = q[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d gnt", i), int'(bus.gnt), int'(q[i].gnt));
            chk($sformatf("row%0d busy", i), int'(bus.busy), int'(q[i].busy));
            chk($sformatf("row%0d out_valid", i), int'(bus.out_valid), int'(q[i].busy));
            chk($sformatf("row%0d out", i), int'(bus.out), q[i].out);
            chk($sformatf("row%0d out_id", i), int'(bus.out_id), q[i].id);
            chk($sformatf("row%0d out_phase", i), int'(bus.out_phase), q[i].ph);
        end

        rst = 1'b0;
        bus.req = '0;
        bus.d_flat = 32'hDEADBEEF;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle%0d busy", c), int'(bus.busy), 0);
            chk($sformatf("idle%0d out_valid", c), int'(bus.out_valid), 0);
            chk($sformatf("idle%0d gnt", c), int'(bus.gnt), 0);
            chk($sformatf("idle%0d out", c), int'(bus.out), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_seq_arbiter.md
Name: mult_seq_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4-phase constant-scaling unit between NREQ requesters.
- On a grant it captures the winner's 8-bit operand and then emits four scaled results, one per cycle: d*C0, d*C1, d*C2, d*C3.
- Each result is tagged with requester id and phase.
- It sits between the requesting front-end lanes and the downstream accumulator/packer.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, id width; must equal clog2(NREQ).
- DW, 8, operand width.
- C0, 8, phase-0 coefficient; legal range 0..8.
- C1, 1, phase-1 coefficient; legal range 0..8.
- C2, 3, phase-2 coefficient; legal range 0..8.
- C3, 7, phase-3 coefficient; legal range 0..8.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  NREQ  per-requester request level.
- d_flat  in  NREQ*DW  operands; requester i uses bits [i*DW +: DW].
- gnt  out  NREQ  one-hot, one-cycle grant; marks capture of that requester's operand.
- busy  out  1  high while a sequence is running.
- out_valid  out  1  result valid.
- out  out  DW+3  scaled result.
- out_id  out  IDW  requester that owns the current result.
- out_phase  out  2  phase index, 0..3.

Behaviour:
- State registers: state (IDLE/RUN), phase[1:0], opnd[DW-1:0], id[IDW-1:0], ptr[IDW-1:0], gnt register.
- Synchronous reset, at any edge with rst=1:
  - state=IDLE, phase=0, opnd=0, id=0, ptr=0, gnt=0.
  - Hence busy=0, out_valid=0, out=0, out_id=0, out_phase=0 in the following cycle.
  - Reset dominates every other event.
- Arbitration point: an edge where (state==IDLE) or (state==RUN and phase==3).
  - Winner = first i with req[i]=1, searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - If a winner exists: opnd<=d_i; id<=i; gnt<=onehot(i); state<=RUN; phase<=0; ptr<=(i+1) mod NREQ.
  - If no winner: state<=IDLE; gnt<=0; ptr unchanged.
- Non-arbitration edges: gnt<=0; phase<=phase+1; req and d_flat are ignored.
- FSM:
  - IDLE -> RUN on winner.
  - RUN stays RUN for phases 0..3.
  - RUN(phase 3) -> RUN(phase 0) on a new winner; back-to-back grants have zero bubble.
  - RUN(phase 3) -> IDLE when there is no winner.
- Outputs (combinational from registers, no input-to-output path):
  - busy = out_valid = (state==RUN).
  - out_phase = phase when RUN, else 0.
  - out_id = id when RUN, else 0.
  - out = opnd*C[phase] zero-extended to DW+3 when RUN, else 0.
  - C[0..3] = C0..C3. With coefficients <=8 there is no overflow; max 255*8=2040.
  - Scaling uses shifts and adds only; no multiplier instance.
- Latency: grant edge E. In the cycles following E, E+1, E+2 and E+3, phases 0..3 are presented. gnt is high only in the phase-0 cycle.
- Requester rules:
  - Hold req and the operand stable until gnt is seen.
  - Operand is sampled only at the grant edge; later changes have no effect.
  - Each gnt consumes one request. Deassert req within 3 cycles after gnt, or be treated as a new request at the next arbitration point.
  - A continuously held req is re-served in round-robin order.
- Boundaries:
  - req asserted mid-sequence waits until the phase-3 edge.
  - Simultaneous requests are resolved purely by ptr.
  - ptr wraps NREQ-1 -> 0.
  - rst during RUN aborts the sequence; no remaining phases are emitted and ptr returns to 0.

Test Plan:
- Reset, then req=0001, d0=0x10.
  - Next 4 cycles: out=128, 16, 48, 112; out_id=0; phases 0..3; gnt=0001 in the first cycle only.
  - Then busy=0.
- req=1111 held from reset, d0..d3=1,2,3,4.
  - Grants in order 0,1,2,3,0 with no idle cycle between sequences.
  - Second sequence outputs 16, 2, 6, 14.
- d2=0xFF, only req[2].
  - out=2040, 255, 765, 1785.
  - After the sequence, ptr=3. A new request from requesters 1 and 3 together grants 3 first.
- Operand changes and new req[1] asserted during phase 1 of requester 0's sequence.
  - Captured value unaffected.
  - Requester 1 granted exactly at the phase-3 edge; its phase 0 follows immediately.
- rst pulsed for 1 cycle during phase 2.
  - Next cycle all outputs 0, no phase-3 result.
  - With req=1010 afterwards, requester 1 wins (ptr reset to 0).
- No requests for 10 cycles after reset.
  - busy, out_valid and gnt stay 0; out=0 throughout.
